// File: rtl/pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// pll_lock_sequencer
//   Sequences the VGA pixel-clock PLL from the 50 MHz reference clock:
//   pulses the PLL reset, qualifies a synchronized `locked`, retries on lock
//   timeout, and releases the downstream system reset once lock is stable.
//
// Ports
//   refclk_i        reference clock, all logic on the rising edge
//   rst_i           synchronous active-high reset
//   pll_locked_i    PLL locked (asynchronous, synchronized internally)
//   force_relock_i  single-cycle request to restart the sequence
//   pll_rst_o       reset to the PLL
//   sys_rst_o       synchronous reset to downstream VGA logic
//   ready_o         high while running with a qualified lock
//   fault_o         high after all retries failed
//   lock_lost_o     one-cycle pulse when lock drops while running
//   retry_cnt_o     PLL reset retries used in the current sequence
// ---------------------------------------------------------------------------
module pll_lock_sequencer #(
   parameter int unsigned RST_CYCLES          = 16,
   parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
   parameter int unsigned MAX_RETRIES         = 3,
   parameter int unsigned RELEASE_DELAY       = 16
) (
   input  logic                                 refclk_i,
   input  logic                                 rst_i,
   input  logic                                 pll_locked_i,
   input  logic                                 force_relock_i,
   output logic                                 pll_rst_o,
   output logic                                 sys_rst_o,
   output logic                                 ready_o,
   output logic                                 fault_o,
   output logic                                 lock_lost_o,
   output logic [$clog2(MAX_RETRIES+1)-1:0]     retry_cnt_o
);

   // Counter widths sized so no counter wraps inside its state
   localparam int unsigned RST_W = $clog2(RST_CYCLES + 1);
   localparam int unsigned STB_W = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned TMO_W = $clog2(LOCK_TIMEOUT_CYCLES + 1);
   localparam int unsigned REL_W = $clog2(RELEASE_DELAY + 1);
   localparam int unsigned RC_W  = $clog2(MAX_RETRIES + 1);

   localparam logic [2:0] S_PRST    = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd1;
   localparam logic [2:0] S_STABLE  = 3'd2;
   localparam logic [2:0] S_RELEASE = 3'd3;
   localparam logic [2:0] S_RUN     = 3'd4;
   localparam logic [2:0] S_FAULT   = 3'd5;

   logic [2:0]       state_q,     state_d;
   logic [1:0]       sync_q;
   logic [RST_W-1:0] prst_cnt_q,  prst_cnt_d;
   logic [STB_W-1:0] stb_cnt_q,   stb_cnt_d;
   logic [TMO_W-1:0] tmo_cnt_q,   tmo_cnt_d;
   logic [REL_W-1:0] rel_cnt_q,   rel_cnt_d;
   logic [RC_W-1:0]  retry_cnt_q, retry_cnt_d;
   logic             pll_rst_q,   pll_rst_d;
   logic             sys_rst_q,   sys_rst_d;
   logic             ready_q,     ready_d;
   logic             fault_q,     fault_d;
   logic             lock_lost_q, lock_lost_d;

   logic             lk;
   logic [TMO_W-1:0] tmo_inc;
   logic             tmo_hit;
   logic [STB_W-1:0] stb_inc;
   logic             stb_done;

   assign lk       = sync_q[1];
   assign tmo_inc  = tmo_cnt_q + TMO_W'(1);
   assign tmo_hit  = (tmo_inc == TMO_W'(LOCK_TIMEOUT_CYCLES));
   assign stb_inc  = stb_cnt_q + STB_W'(1);
   assign stb_done = (stb_inc == STB_W'(LOCK_STABLE_CYCLES));

   // State, counters, synchronizer and registered outputs
   always_ff @(posedge refclk_i) begin
      if (rst_i) begin
         state_q     <= S_PRST;
         sync_q      <= 2'b00;
         prst_cnt_q  <= '0;
         stb_cnt_q   <= '0;
         tmo_cnt_q   <= '0;
         rel_cnt_q   <= '0;
         retry_cnt_q <= '0;
         pll_rst_q   <= 1'b1;
         sys_rst_q   <= 1'b1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= {sync_q[0], pll_locked_i};
         prst_cnt_q  <= prst_cnt_d;
         stb_cnt_q   <= stb_cnt_d;
         tmo_cnt_q   <= tmo_cnt_d;
         rel_cnt_q   <= rel_cnt_d;
         retry_cnt_q <= retry_cnt_d;
         pll_rst_q   <= pll_rst_d;
         sys_rst_q   <= sys_rst_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
         lock_lost_q <= lock_lost_d;
      end
   end

   // Next-state and counter logic
   always_comb begin
      state_d     = state_q;
      prst_cnt_d  = prst_cnt_q;
      stb_cnt_d   = stb_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      rel_cnt_d   = rel_cnt_q;
      retry_cnt_d = retry_cnt_q;
      lock_lost_d = 1'b0;

      case (state_q)
         S_PRST: begin
            if (prst_cnt_q == RST_W'(RST_CYCLES - 1)) begin
               state_d    = S_WAIT;
               prst_cnt_d = '0;
               tmo_cnt_d  = '0;
               stb_cnt_d  = '0;
            end else begin
               prst_cnt_d = prst_cnt_q + RST_W'(1);
            end
         end

         S_WAIT: begin
            tmo_cnt_d = tmo_inc;
            // The first locked cycle already counts as stable cycle one
            if (lk && (LOCK_STABLE_CYCLES == 1)) begin
               state_d   = S_RELEASE;
               rel_cnt_d = '0;
            end else if (tmo_hit) begin
               if (retry_cnt_q < RC_W'(MAX_RETRIES)) begin
                  retry_cnt_d = retry_cnt_q + RC_W'(1);
                  state_d     = S_PRST;
                  prst_cnt_d  = '0;
               end else begin
                  state_d = S_FAULT;
               end
            end else if (lk) begin
               state_d   = S_STABLE;
               stb_cnt_d = STB_W'(1);
            end
         end

         S_STABLE: begin
            tmo_cnt_d = tmo_inc;
            // Stable completion takes precedence over a coincident timeout
            if (lk && stb_done) begin
               state_d   = S_RELEASE;
               stb_cnt_d = stb_inc;
               rel_cnt_d = '0;
            end else if (tmo_hit) begin
               stb_cnt_d = '0;
               if (retry_cnt_q < RC_W'(MAX_RETRIES)) begin
                  retry_cnt_d = retry_cnt_q + RC_W'(1);
                  state_d     = S_PRST;
                  prst_cnt_d  = '0;
               end else begin
                  state_d = S_FAULT;
               end
            end else if (lk) begin
               stb_cnt_d = stb_inc;
            end else begin
               state_d   = S_WAIT;
               stb_cnt_d = '0;
            end
         end

         S_RELEASE: begin
            if (!lk) begin
               state_d    = S_PRST;
               prst_cnt_d = '0;
            end else if (rel_cnt_q == REL_W'(RELEASE_DELAY - 1)) begin
               state_d   = S_RUN;
               rel_cnt_d = '0;
            end else begin
               rel_cnt_d = rel_cnt_q + REL_W'(1);
            end
         end

         S_RUN: begin
            if (!lk) begin
               state_d     = S_PRST;
               prst_cnt_d  = '0;
               retry_cnt_d = '0;
               lock_lost_d = 1'b1;
            end
         end

         S_FAULT: begin
            state_d = S_FAULT;
         end

         default: begin
            state_d    = S_PRST;
            prst_cnt_d = '0;
         end
      endcase

      // Relock request overrides every lock/timeout event
      if (force_relock_i) begin
         state_d     = S_PRST;
         prst_cnt_d  = '0;
         stb_cnt_d   = '0;
         retry_cnt_d = '0;
         lock_lost_d = 1'b0;
      end
   end

   // Output values follow the state being entered so they register with it
   always_comb begin
      pll_rst_d = 1'b0;
      sys_rst_d = 1'b1;
      ready_d   = 1'b0;
      fault_d   = 1'b0;
      case (state_d)
         S_PRST:    pll_rst_d = 1'b1;
         S_RUN: begin
            sys_rst_d = 1'b0;
            ready_d   = 1'b1;
         end
         S_FAULT: begin
            pll_rst_d = 1'b1;
            fault_d   = 1'b1;
         end
         default:   pll_rst_d = 1'b0;
      endcase
   end

   assign pll_rst_o   = pll_rst_q;
   assign sys_rst_o   = sys_rst_q;
   assign ready_o     = ready_q;
   assign fault_o     = fault_q;
   assign lock_lost_o = lock_lost_q;
   assign retry_cnt_o = retry_cnt_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pll_lock_sequencer
//   Table-driven bench: each row holds inputs, a repeat count and the
//   outputs expected after every one of those clock edges. Expected values
//   are queued when the inputs are driven and checked after the edge.
// ---------------------------------------------------------------------------
module tb_pll_lock_sequencer;

   typedef struct {
      int unsigned n;
      logic        rst;
      logic        lk;
      logic        frc;
      logic [6:0]  exp;   // {pll_rst, sys_rst, ready, fault, lock_lost, retry_cnt[1:0]}
   } vec_t;

   typedef struct {
      int         row;
      logic [6:0] exp;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       pll_locked;
   logic       force_relock;
   logic       pll_rst;
   logic       sys_rst;
   logic       ready;
   logic       fault;
   logic       lock_lost;
   logic [1:0] retry_cnt;

   vec_t tbl[$];
   exp_t sb[$];
   int   n_checks;
   int   n_fail;

   pll_lock_sequencer #(
      .RST_CYCLES         (4),
      .LOCK_STABLE_CYCLES (8),
      .LOCK_TIMEOUT_CYCLES(32),
      .MAX_RETRIES        (2),
      .RELEASE_DELAY      (4)
   ) dut (
      .refclk_i      (clk),
      .rst_i         (rst),
      .pll_locked_i  (pll_locked),
      .force_relock_i(force_relock),
      .pll_rst_o     (pll_rst),
      .sys_rst_o     (sys_rst),
      .ready_o       (ready),
      .fault_o       (fault),
      .lock_lost_o   (lock_lost),
      .retry_cnt_o   (retry_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input int unsigned n, input logic r, input logic l, input logic f,
                      input logic p, input logic s, input logic rd, input logic ft,
                      input logic ll, input logic [1:0] rc);
      vec_t v;
      v.n   = n;
      v.rst = r;
      v.lk  = l;
      v.frc = f;
      v.exp = {p, s, rd, ft, ll, rc};
      tbl.push_back(v);
   endtask

   // Scoreboard check, shortly after each rising edge
   always @(posedge clk) begin
      exp_t e;
      logic [6:0] got;
      #1;
      if (sb.size() > 0) begin
         e   = sb.pop_front();
         got = {pll_rst, sys_rst, ready, fault, lock_lost, retry_cnt};
         n_checks++;
         if (got !== e.exp) begin
            n_fail++;
            $display("FAIL row%0d @%0t: got pll_rst,sys_rst,ready,fault,lock_lost,retry=%b want %b",
                     e.row, $time, got, e.exp);
         end
      end
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      n_checks     = 0;
      n_fail       = 0;
      rst          = 1'b1;
      pll_locked   = 1'b0;
      force_relock = 1'b0;

      // Nominal lock, steady run, then forced relock from RUN
      add( 2, 1,0,0, 1,1,0,0,0, 2'd0);
      add( 3, 0,0,0, 1,1,0,0,0, 2'd0);
      add( 5, 0,0,0, 0,1,0,0,0, 2'd0);
      add(13, 0,1,0, 0,1,0,0,0, 2'd0);
      add( 4, 0,1,0, 0,0,1,0,0, 2'd0);
      // Loss of lock in RUN and relock
      add( 2, 0,0,0, 0,0,1,0,0, 2'd0);
      add( 1, 0,0,0, 1,1,0,0,1, 2'd0);
      add( 3, 0,0,0, 1,1,0,0,0, 2'd0);
      add( 1, 0,1,0, 0,1,0,0,0, 2'd0);
      add(12, 0,1,0, 0,1,0,0,0, 2'd0);
      add( 1, 0,1,0, 0,0,1,0,0, 2'd0);
      add( 1, 0,1,1, 1,1,0,0,0, 2'd0);
      add( 3, 0,1,0, 1,1,0,0,0, 2'd0);
      add( 1, 0,1,0, 0,1,0,0,0, 2'd0);
      // Glitch after five locked cycles restarts stability qualification
      add( 2, 1,0,0, 1,1,0,0,0, 2'd0);
      add( 3, 0,0,0, 1,1,0,0,0, 2'd0);
      add( 1, 0,0,0, 0,1,0,0,0, 2'd0);
      add( 5, 0,1,0, 0,1,0,0,0, 2'd0);
      add( 1, 0,0,0, 0,1,0,0,0, 2'd0);
      add(13, 0,1,0, 0,1,0,0,0, 2'd0);
      add( 1, 0,1,0, 0,0,1,0,0, 2'd0);
      // Never locks: two retries, fault, then forced relock
      add( 2, 1,0,0, 1,1,0,0,0, 2'd0);
      add( 3, 0,0,0, 1,1,0,0,0, 2'd0);
      add(32, 0,0,0, 0,1,0,0,0, 2'd0);
      add( 4, 0,0,0, 1,1,0,0,0, 2'd1);
      add(32, 0,0,0, 0,1,0,0,0, 2'd1);
      add( 4, 0,0,0, 1,1,0,0,0, 2'd2);
      add(32, 0,0,0, 0,1,0,0,0, 2'd2);
      add( 6, 0,0,0, 1,1,0,1,0, 2'd2);
      add( 1, 0,0,1, 1,1,0,0,0, 2'd0);
      add( 3, 0,0,0, 1,1,0,0,0, 2'd0);
      add( 1, 0,0,0, 0,1,0,0,0, 2'd0);
      // Reset during STABLE, then during RELEASE
      add( 2, 1,0,0, 1,1,0,0,0, 2'd0);
      add( 3, 0,0,0, 1,1,0,0,0, 2'd0);
      add( 1, 0,0,0, 0,1,0,0,0, 2'd0);
      add( 4, 0,1,0, 0,1,0,0,0, 2'd0);
      add( 1, 1,1,0, 1,1,0,0,0, 2'd0);
      add( 3, 0,1,0, 1,1,0,0,0, 2'd0);
      add( 1, 0,1,0, 0,1,0,0,0, 2'd0);
      add( 8, 0,1,0, 0,1,0,0,0, 2'd0);
      add( 1, 1,1,0, 1,1,0,0,0, 2'd0);
      add( 3, 0,1,0, 1,1,0,0,0, 2'd0);
      add( 1, 0,1,0, 0,1,0,0,0, 2'd0);
      add(11, 0,1,0, 0,1,0,0,0, 2'd0);
      add( 1, 0,1,0, 0,0,1,0,0, 2'd0);
      // Stable completion on the timeout cycle wins
      add( 2, 1,0,0, 1,1,0,0,0, 2'd0);
      add( 3, 0,0,0, 1,1,0,0,0, 2'd0);
      add(23, 0,0,0, 0,1,0,0,0, 2'd0);
      add(13, 0,1,0, 0,1,0,0,0, 2'd0);
      add( 1, 0,1,0, 0,0,1,0,0, 2'd0);
      // One cycle later the timeout wins and a retry follows
      add( 2, 1,0,0, 1,1,0,0,0, 2'd0);
      add( 3, 0,0,0, 1,1,0,0,0, 2'd0);
      add(24, 0,0,0, 0,1,0,0,0, 2'd0);
      add( 8, 0,1,0, 0,1,0,0,0, 2'd0);
      add( 4, 0,1,0, 1,1,0,0,0, 2'd1);
      add( 1, 0,1,0, 0,1,0,0,0, 2'd1);
      add(11, 0,1,0, 0,1,0,0,0, 2'd1);
      add( 1, 0,1,0, 0,0,1,0,0, 2'd1);
      // Lock lost during RELEASE keeps the retry count
      add( 2, 1,0,0, 1,1,0,0,0, 2'd0);
      add( 3, 0,0,0, 1,1,0,0,0, 2'd0);
      add(32, 0,0,0, 0,1,0,0,0, 2'd0);
      add( 1, 0,0,0, 1,1,0,0,0, 2'd1);
      add( 3, 0,1,0, 1,1,0,0,0, 2'd1);
      add( 1, 0,1,0, 0,1,0,0,0, 2'd1);
      add( 7, 0,1,0, 0,1,0,0,0, 2'd1);
      add( 2, 0,0,0, 0,1,0,0,0, 2'd1);
      add( 1, 0,0,0, 1,1,0,0,0, 2'd1);
      add( 3, 0,0,0, 1,1,0,0,0, 2'd1);
      add( 1, 0,0,0, 0,1,0,0,0, 2'd1);

      foreach (tbl[i]) begin
         for (int k = 0; k < int'(tbl[i].n); k++) begin
            exp_t e;
            @(negedge clk);
            rst          = tbl[i].rst;
            pll_locked   = tbl[i].lk;
            force_relock = tbl[i].frc;
            e.row        = i;
            e.exp        = tbl[i].exp;
            sb.push_back(e);
         end
      end
      @(negedge clk);
      @(negedge clk);

      // Release latency from lock rise to ready, bounded
      pll_locked = 1'b1;
      lat        = 0;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk);
         #1;
         if (ready === 1'b1) begin
            lat = c;
            break;
         end
      end
      n_checks++;
      if (lat != 14) begin
         n_fail++;
         $display("FAIL release_latency: got %0d cycles want 14", lat);
      end
      n_checks++;
      if (retry_cnt !== 2'd1 || sys_rst !== 1'b0 || pll_rst !== 1'b0) begin
         n_fail++;
         $display("FAIL run_after_retry: got retry=%0d sys_rst=%b pll_rst=%b want 1,0,0",
                  retry_cnt, sys_rst, pll_rst);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
Sequences the VGA pixel-clock PLL: drives its reset, qualifies its `locked` output, retries on lock failure, and releases a registered system reset to downstream VGA logic only after the lock is stable. Runs on the PLL reference clock (50 MHz board clock), so it stays alive while the PLL is unlocked. Sits between the board reset/clock pins and the PLL wrapper plus the VGA timing/pixel logic.

Parameters:
RST_CYCLES, 16, cycles `pll_rst` is held high per attempt (≥1)
LOCK_STABLE_CYCLES, 1024, consecutive synchronized-locked cycles required before release (≥1)
LOCK_TIMEOUT_CYCLES, 65536, max cycles from PLL reset release to qualified lock (> LOCK_STABLE_CYCLES)
MAX_RETRIES, 3, PLL reset retries after first attempt before declaring fault
RELEASE_DELAY, 16, cycles `sys_rst` stays high after qualified lock (≥1)

Ports:
refclk  input  1  reference clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
pll_locked  input  1  PLL `locked`; asynchronous, synchronized internally
force_relock  input  1  single-cycle request to restart the sequence
pll_rst  output  1  reset to the PLL
sys_rst  output  1  synchronous reset to downstream VGA logic
ready  output  1  high while in RUN
fault  output  1  high while in FAULT
lock_lost  output  1  one-cycle pulse on loss of lock in RUN
retry_cnt  output  $clog2(MAX_RETRIES+1)  retries used in the current sequence

Behaviour:
- One clock, `refclk`. Reset is synchronous and active-high on `rst`. All outputs are registered.
- Reset values:
  - state = PRST
  - `pll_rst`=1, `sys_rst`=1
  - `ready`=0, `fault`=0, `lock_lost`=0, `retry_cnt`=0
  - all counters = 0; synchronizer flops = 0
- `pll_locked` passes a 2-flop synchronizer. `lk` denotes the synchronized value, which has 2 cycles of latency.
- PRST:
  - `pll_rst`=1, `sys_rst`=1, `ready`=0.
  - Stays exactly RST_CYCLES cycles, then goes to WAIT.
  - Timeout counter is cleared on exit.
- WAIT:
  - `pll_rst`=0. Timeout counter increments every cycle.
  - `lk`=1 → STABLE, with stable counter = 1.
- STABLE:
  - Timeout counter keeps incrementing. Stable counter increments while `lk`=1.
  - `lk`=0 → WAIT, stable counter cleared; the timeout counter is not cleared.
  - Stable counter reaches LOCK_STABLE_CYCLES → RELEASE.
  - If stable completion and timeout occur in the same cycle, stable completion wins.
- Timeout (counter reaches LOCK_TIMEOUT_CYCLES in WAIT or STABLE):
  - If `retry_cnt` < MAX_RETRIES: increment `retry_cnt`, go to PRST.
  - Otherwise go to FAULT.
- RELEASE:
  - `sys_rst`=1 for exactly RELEASE_DELAY cycles, then RUN.
  - `lk`=0 here → PRST, with the retry counter unchanged.
- RUN:
  - `sys_rst`=0, `ready`=1.
  - `lk`=0 → PRST with `retry_cnt` cleared. `lock_lost` pulses for 1 cycle, and `sys_rst` and `pll_rst` are 1 on that same cycle.
- FAULT:
  - `pll_rst`=1, `sys_rst`=1, `fault`=1.
  - Held until `rst` or `force_relock`.
- `force_relock`=1 in any state: next cycle is PRST, with `retry_cnt`=0, `fault`=0, `ready`=0, `sys_rst`=1.
- Priority: `rst` > `force_relock` > timeout/lock events.
- Reset mid-operation: `rst` returns the block to its reset values on the next edge from any state, with no partial release.
- Counters saturate-free: widths are sized by `$clog2` of their parameter so they never wrap within a state.

Test Plan:
All scenarios use parameters RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, RELEASE_DELAY=4.
1. Nominal lock: release `rst`; `pll_locked` rises 5 cycles after `pll_rst` falls → `pll_rst` high exactly 4 cycles; `sys_rst` falls exactly 2+8+4 cycles after `pll_locked` rises; `ready`=1; `retry_cnt`=0.
2. Glitchy lock: in STABLE, drop `pll_locked` for 1 cycle after 5 locked cycles → no release. 8 fresh consecutive cycles are required; release still happens if within 32 cycles of PLL reset release, else `retry_cnt`=1 and `pll_rst` pulses 4 cycles again.
3. Never locks: `pll_locked`=0 → 3 `pll_rst` pulses (`retry_cnt` 0→1→2), then `fault`=1, `pll_rst`=1, `sys_rst`=1 permanently. A `force_relock` pulse → `fault`=0, `retry_cnt`=0, new PRST.
4. Loss in RUN: after `ready`=1, drop `pll_locked` → within 3 cycles `lock_lost` pulses exactly once, `sys_rst`=1, `ready`=0, `pll_rst`=1 for 4 cycles; relock yields `ready` again.
5. Reset mid-operation: assert `rst` during STABLE and during RELEASE → next edge all outputs at reset values; after deassert, full PRST of 4 cycles.
6. Timeout/stable tie: lock arrives so the 8th stable cycle equals timeout cycle 32 → RELEASE entered, `retry_cnt` unchanged.
